// File: rtl/matrix_mult_array.sv
// matrix_mult_array: C = A x B over signed DATA_W entries, row-major cell
// dispatch onto LANES independent MAC lanes, fixed-priority writeback.
//
// Ports:
//   clk, rst (async active-low)
//   wa_x/wa_y/wa_data/wa_we : A write (column, row), accepted while idle
//   wb_x/wb_y/wb_data/wb_we : B write (column, row), accepted while idle
//   start, size_m/k/n       : job launch, sizes sampled with start
//   rd_x/rd_y -> rd_data    : C read, registered, read-before-write
//   busy, done, err         : job status; done is a 1-cycle pulse
//   sat                     : sticky clamp flag (MATRIX_MULT_SATURATE_EN only)
//
// Optional macro MATRIX_MULT_SATURATE_EN clamps results instead of wrapping.
module matrix_mult_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wa_x,
    input  logic [ADDR_W-1:0] wa_y,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wa_we,
    input  logic [ADDR_W-1:0] wb_x,
    input  logic [ADDR_W-1:0] wb_y,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_we,
    input  logic              start,
    input  logic [ADDR_W:0]   size_m,
    input  logic [ADDR_W:0]   size_k,
    input  logic [ADDR_W:0]   size_n,
    input  logic [ADDR_W-1:0] rd_x,
    input  logic [ADDR_W-1:0] rd_y,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef MATRIX_MULT_SATURATE_EN
    ,
    output logic              sat
`endif
);

    localparam int DIM = 1 << ADDR_W;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW  = ADDR_W + 1;
    localparam logic [SW-1:0] DIM_S = SW'(DIM);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FIN} state_t;

    state_t state, state_nxt;

    // Storage, indexed [row][col]
    logic [DATA_W-1:0] mem_a [DIM][DIM];
    logic [DATA_W-1:0] mem_b [DIM][DIM];
    logic [DATA_W-1:0] mem_c [DIM][DIM];

    logic [SW-1:0]     m_q, k_q, n_q;
    logic [SW-1:0]     m_last, k_last, n_last;
    logic [ADDR_W-1:0] row_cnt, col_cnt;

    logic              host_ok, start_acc, start_legal;
    logic              last_cell, dispatch;

    logic [LANES-1:0]         lane_busy, lane_wb;
    logic [ADDR_W-1:0]        lane_row [LANES];
    logic [ADDR_W-1:0]        lane_col [LANES];
    logic [ADDR_W-1:0]        lane_k   [LANES];
    logic signed [ACC_W-1:0]  lane_acc [LANES];
    logic signed [ACC_W-1:0]  lane_prod[LANES];

    logic              disp_ok, grant_ok;
    logic [LW-1:0]     disp_lane, grant_lane;
    logic [ADDR_W-1:0] grant_row, grant_col;
    logic [DATA_W-1:0] grant_res;
    logic              grant_ovf;

    function automatic logic signed [ACC_W-1:0] mac_prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    assign host_ok     = (state == IDLE);
    assign start_acc   = host_ok && start;
    assign start_legal = (size_m != '0) && (size_m <= DIM_S)
                      && (size_k != '0) && (size_k <= DIM_S)
                      && (size_n != '0) && (size_n <= DIM_S);

    assign m_last    = m_q - SW'(1);
    assign k_last    = k_q - SW'(1);
    assign n_last    = n_q - SW'(1);
    assign last_cell = ({1'b0, row_cnt} == m_last)
                    && ({1'b0, col_cnt} == n_last);
    assign dispatch  = (state == DISPATCH) && disp_ok;

    // Lowest-index idle lane takes the next cell
    always_comb begin
        disp_ok   = 1'b0;
        disp_lane = '0;
        for (int i = LANES-1; i >= 0; i--) begin
            if (!lane_busy[i]) begin
                disp_ok   = 1'b1;
                disp_lane = LW'(i);
            end
        end
    end

    // Lowest-index pending lane owns the single C write port
    always_comb begin
        grant_ok   = 1'b0;
        grant_lane = '0;
        for (int i = LANES-1; i >= 0; i--) begin
            if (lane_wb[i]) begin
                grant_ok   = 1'b1;
                grant_lane = LW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_prod[i] = mac_prod(mem_a[lane_row[i]][lane_k[i]],
                                    mem_b[lane_k[i]][lane_col[i]]);
        end
    end

    assign grant_row = lane_row[grant_lane];
    assign grant_col = lane_col[grant_lane];

`ifdef MATRIX_MULT_SATURATE_EN
    logic signed [ACC_W-1:0]   grant_acc;
    logic [ACC_W-DATA_W:0]     grant_hi;

    assign grant_acc = lane_acc[grant_lane];
    assign grant_hi  = grant_acc[ACC_W-1:DATA_W-1];

    // Result fits only if every bit from the DATA_W sign bit upward agrees
    always_comb begin
        grant_ovf = !((&grant_hi) || !(|grant_hi));
        grant_res = grant_acc[DATA_W-1:0];
        if (grant_ovf) begin
            grant_res = grant_acc[ACC_W-1]
                      ? {1'b1, {(DATA_W-1){1'b0}}}
                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        grant_ovf = 1'b0;
        grant_res = lane_acc[grant_lane][DATA_W-1:0];
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = start_legal ? DISPATCH : FIN;
            DISPATCH: if (dispatch && last_cell) state_nxt = DRAIN;
            DRAIN:    if (lane_busy == '0) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == DISPATCH) || (state == DRAIN);
        done = (state == FIN);
    end

    // Job sizes, dispatch counters, status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            err     <= 1'b0;
`ifdef MATRIX_MULT_SATURATE_EN
            sat     <= 1'b0;
`endif
        end else begin
            if (start_acc) begin
                err <= !start_legal;
`ifdef MATRIX_MULT_SATURATE_EN
                sat <= 1'b0;
`endif
                if (start_legal) begin
                    m_q     <= size_m;
                    k_q     <= size_k;
                    n_q     <= size_n;
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
            end
            if (dispatch) begin
                if ({1'b0, col_cnt} == n_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + ADDR_W'(1);
                end else begin
                    col_cnt <= col_cnt + ADDR_W'(1);
                end
            end
`ifdef MATRIX_MULT_SATURATE_EN
            if (grant_ok && grant_ovf) sat <= 1'b1;
`endif
        end
    end

    // Lanes: idle -> MAC for K cycles -> hold result until granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_busy <= '0;
            lane_wb   <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_row[i] <= '0;
                lane_col[i] <= '0;
                lane_k[i]   <= '0;
                lane_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (dispatch && disp_lane == LW'(i)) begin
                    lane_busy[i] <= 1'b1;
                    lane_wb[i]   <= 1'b0;
                    lane_row[i]  <= row_cnt;
                    lane_col[i]  <= col_cnt;
                    lane_k[i]    <= '0;
                    lane_acc[i]  <= '0;
                end else if (lane_busy[i] && !lane_wb[i]) begin
                    lane_acc[i] <= lane_acc[i] + lane_prod[i];
                    if ({1'b0, lane_k[i]} == k_last) lane_wb[i] <= 1'b1;
                    else lane_k[i] <= lane_k[i] + ADDR_W'(1);
                end else if (lane_wb[i] && grant_lane == LW'(i)) begin
                    lane_busy[i] <= 1'b0;
                    lane_wb[i]   <= 1'b0;
                end
            end
        end
    end

    // Memories are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (host_ok && wa_we) mem_a[wa_y][wa_x] <= wa_data;
        if (host_ok && wb_we) mem_b[wb_y][wb_x] <= wb_data;
        if (grant_ok) mem_c[grant_row][grant_col] <= grant_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem_c[rd_y][rd_x];
    end

endmodule

// File: tb/tb_matrix_mult_array.sv
// tb_matrix_mult_array: randomized scoreboard bench for matrix_mult_array.
// Stimulus pushes expected jobs; a monitor pops them on done and reads C.
module tb_matrix_mult_array;

    localparam int AW  = 5;
    localparam int DW  = 16;
    localparam int DIM = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] wa_x = '0, wa_y = '0, wb_x = '0, wb_y = '0;
    logic [DW-1:0] wa_data = '0, wb_data = '0;
    logic          wa_we = 1'b0, wb_we = 1'b0, start = 1'b0;
    logic [AW:0]   size_m = '0, size_k = '0, size_n = '0;
    logic [AW-1:0] rd_x = '0, rd_y = '0;
    logic [DW-1:0] rd_data;
    logic          busy, done, err;
`ifdef MATRIX_MULT_SATURATE_EN
    logic          sat;
`endif

    always #5 clk = ~clk;

    matrix_mult_array #(.ADDR_W(AW), .DATA_W(DW), .LANES(4)) dut (
        .clk(clk), .rst(rst),
        .wa_x(wa_x), .wa_y(wa_y), .wa_data(wa_data), .wa_we(wa_we),
        .wb_x(wb_x), .wb_y(wb_y), .wb_data(wb_data), .wb_we(wb_we),
        .start(start), .size_m(size_m), .size_k(size_k), .size_n(size_n),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
`ifdef MATRIX_MULT_SATURATE_EN
        , .sat(sat)
`endif
    );

    typedef struct {
        bit err;
        bit chk_sat;
        bit sat;
        int m;
        int n;
    } job_t;

    job_t          job_q[$];
    logic [DW-1:0] c_q[$];

    logic [DW-1:0] ma [DIM][DIM];
    logic [DW-1:0] mb [DIM][DIM];
    logic [DW-1:0] mc [DIM][DIM];

    int tests = 0, fails = 0;
    int issued = 0, checked = 0;
    int last_m = 1, last_n = 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic write_a(input int r, input int c, input logic [DW-1:0] v);
        wa_y = AW'(r); wa_x = AW'(c); wa_data = v; wa_we = 1'b1;
        @(negedge clk);
        wa_we = 1'b0;
        ma[r][c] = v;
    endtask

    task automatic write_b(input int r, input int c, input logic [DW-1:0] v);
        wb_y = AW'(r); wb_x = AW'(c); wb_data = v; wb_we = 1'b1;
        @(negedge clk);
        wb_we = 1'b0;
        mb[r][c] = v;
    endtask

    task automatic fill_random(input int m, input int k, input int n);
        for (int r = 0; r < m; r++)
            for (int c = 0; c < k; c++) write_a(r, c, DW'($urandom));
        for (int r = 0; r < k; r++)
            for (int c = 0; c < n; c++) write_b(r, c, DW'($urandom));
    endtask

    // Reference: plain dot products in 64-bit arithmetic
    task automatic expect_job(input int m, input int k, input int n);
        job_t j;
        bit   s = 1'b0;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                longint acc = 0;
                logic [DW-1:0] res;
                for (int x = 0; x < k; x++)
                    acc += longint'($signed(ma[r][x])) * longint'($signed(mb[x][c]));
`ifdef MATRIX_MULT_SATURATE_EN
                if (acc > 32767) begin
                    res = 16'h7fff; s = 1'b1;
                end else if (acc < -32768) begin
                    res = 16'h8000; s = 1'b1;
                end else begin
                    res = acc[15:0];
                end
`else
                res = acc[15:0];
`endif
                mc[r][c] = res;
                c_q.push_back(res);
            end
        end
        j.err = 1'b0; j.chk_sat = 1'b1; j.sat = s; j.m = m; j.n = n;
        job_q.push_back(j);
        issued++;
        last_m = m; last_n = n;
    endtask

    task automatic expect_err();
        job_t j;
        for (int r = 0; r < last_m; r++)
            for (int c = 0; c < last_n; c++) c_q.push_back(mc[r][c]);
        j.err = 1'b1; j.chk_sat = 1'b0; j.sat = 1'b0;
        j.m = last_m; j.n = last_n;
        job_q.push_back(j);
        issued++;
    endtask

    task automatic wait_checked(input string name);
        int cyc = 0;
        while (checked != issued && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (checked != issued) begin
            tests++; fails++;
            $display("FAIL %s: readback timeout, got %0d expected %0d",
                     name, checked, issued);
            finish_tb();
        end
    endtask

    // Legal job; while running, also pokes A/B writes and a stray start
    task automatic run_job(input string name, input int m, input int k,
                           input int n);
        int cyc = 0;
        bit early_idle = 1'b0;
        expect_job(m, k, n);
        size_m = (AW+1)'(m); size_k = (AW+1)'(k); size_n = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        check({name, "_busy_rise"}, busy, 1);
        wa_y = '0; wa_x = '0; wa_data = ~ma[0][0]; wa_we = 1'b1;
        wb_y = '0; wb_x = '0; wb_data = ~mb[0][0]; wb_we = 1'b1;
        size_k = '0; size_m = 6'd33;
        @(negedge clk);
        start = 1'b0; wa_we = 1'b0; wb_we = 1'b0;
        size_m = (AW+1)'($urandom); size_k = (AW+1)'($urandom);
        size_n = (AW+1)'($urandom);
        while (!done && cyc < 20000) begin
            if (!busy) early_idle = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: done timeout, got 0 expected 1", name);
            finish_tb();
        end
        check({name, "_busy_until_done"}, early_idle, 0);
        wait_checked(name);
    endtask

    task automatic run_err(input string name, input int m, input int k,
                           input int n);
        int cyc = 0;
        expect_err();
        size_m = (AW+1)'(m); size_k = (AW+1)'(k); size_n = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: done timeout, got 0 expected 1", name);
            finish_tb();
        end
        wait_checked(name);
        check({name, "_err_hold"}, err, 1);
    endtask

    // Monitor: pops an expected job on every done and reads C back
    initial begin
        job_t j;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (job_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_done: got 1 expected 0");
                end else begin
                    j = job_q.pop_front();
                    check("err", err, j.err);
                    check("busy_at_done", busy, 0);
`ifdef MATRIX_MULT_SATURATE_EN
                    if (j.chk_sat) check("sat", sat, j.sat);
`endif
                    for (int r = 0; r < j.m; r++) begin
                        for (int c = 0; c < j.n; c++) begin
                            rd_y = AW'(r); rd_x = AW'(c);
                            @(negedge clk);
                            if (r == 0 && c == 0) check("done_pulse", done, 0);
                            e = c_q.pop_front();
                            check($sformatf("c[%0d][%0d]", r, c), rd_data, e);
                        end
                    end
                    checked++;
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Identity times [[1,2],[3,4]]
        write_a(0, 0, 16'd1); write_a(0, 1, 16'd0);
        write_a(1, 0, 16'd0); write_a(1, 1, 16'd1);
        write_b(0, 0, 16'd1); write_b(0, 1, 16'd2);
        write_b(1, 0, 16'd3); write_b(1, 1, 16'd4);
        run_job("identity", 2, 2, 2);

        // [1,-2,3] x [4,5,6]^T = 12
        write_a(0, 0, 16'd1); write_a(0, 1, -16'sd2); write_a(0, 2, 16'd3);
        write_b(0, 0, 16'd4); write_b(1, 0, 16'd5); write_b(2, 0, 16'd6);
        run_job("signed_rect", 1, 3, 1);

        // 9 cells on 4 lanes, every entry 1*2+1*2
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++) write_a(r, c, 16'd1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) write_b(r, c, 16'd2);
        run_job("contention", 3, 2, 3);

        run_err("illegal_k0", 3, 0, 3);
        run_err("illegal_m33", 33, 2, 3);
        run_job("legal_after_err", 3, 2, 3);

        // 32767*32767*2 overflows DATA_W
        write_a(0, 0, 16'h7fff); write_a(0, 1, 16'h7fff);
        write_b(0, 0, 16'h7fff); write_b(1, 0, 16'h7fff);
        run_job("overflow", 1, 2, 1);

        for (int t = 0; t < 8; t++) begin
            int m = int'($urandom_range(1, 6));
            int k = int'($urandom_range(1, 6));
            int n = int'($urandom_range(1, 6));
            fill_random(m, k, n);
            run_job($sformatf("rand%0d", t), m, k, n);
        end

        fill_random(2, 32, 32);
        run_job("max_dim", 2, 32, 32);

        // Reset mid-dispatch, then rerun with A/B untouched
        fill_random(4, 4, 4);
        size_m = 6'd4; size_k = 6'd4; size_n = 6'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wa_y = '0; wa_x = '0; wa_data = ~ma[0][0]; wa_we = 1'b1;
        wb_y = '0; wb_x = '0; wb_data = ~mb[0][0]; wb_we = 1'b1;
        @(negedge clk);
        wa_we = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_job("rerun_after_rst", 4, 4, 4);

        repeat (3) @(negedge clk);
        finish_tb();
    end

endmodule
